// File: rtl/uart_alu_pkg.sv
// ---------------------------------------------------------------------------
// uart_alu_pkg
// Shared definitions for the framed UART/ALU bridge:
//   - one-hot state bit positions and the state_t enum built from them
//   - bit positions inside the optional trailing status byte
//   - the byte sent back when a stalled frame is aborted
//   - helpers that derive the byte count and byte-index width from NB_DATA
// No ports; imported with "import uart_alu_pkg::*;".
// ---------------------------------------------------------------------------
package uart_alu_pkg;

  localparam int ST_IDLE_BIT    = 0;
  localparam int ST_READ_OP_BIT = 1;
  localparam int ST_READ_A_BIT  = 2;
  localparam int ST_READ_B_BIT  = 3;
  localparam int ST_COMPUTE_BIT = 4;
  localparam int ST_SEND_BIT    = 5;
  localparam int ST_WAIT_TX_BIT = 6;
  localparam int NUM_STATES     = 7;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE    = NUM_STATES'(1 << ST_IDLE_BIT),
    S_READ_OP = NUM_STATES'(1 << ST_READ_OP_BIT),
    S_READ_A  = NUM_STATES'(1 << ST_READ_A_BIT),
    S_READ_B  = NUM_STATES'(1 << ST_READ_B_BIT),
    S_COMPUTE = NUM_STATES'(1 << ST_COMPUTE_BIT),
    S_SEND    = NUM_STATES'(1 << ST_SEND_BIT),
    S_WAIT_TX = NUM_STATES'(1 << ST_WAIT_TX_BIT)
  } state_t;

  localparam int STATUS_ZERO_BIT = 0;
  localparam int STATUS_NEG_BIT  = 1;

  localparam logic [7:0] ERR_BYTE = 8'hE1;

  function automatic int nb_bytes(input int nb_data);
    return nb_data / 8;
  endfunction

  // One extra index value is reserved so the status byte can follow the
  // result bytes using the same counter.
  function automatic int idx_width(input int nb_data);
    return $clog2(nb_bytes(nb_data) + 1);
  endfunction

endpackage

// File: rtl/uart_alu_frame_if_rx_timeout_timer.sv
// ---------------------------------------------------------------------------
// rx_timeout_timer
// Counts idle cycles while a frame is waiting for its next operand byte and
// raises a one-cycle expire pulse on the TIMEOUT_CYCLES-th consecutive idle
// cycle. Only meaningful for TIMEOUT_CYCLES >= 1; the parent bypasses it
// entirely when the timeout is disabled.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous, active-low
//   clear     - restart the count (a byte was popped / not in an operand state)
//   count_en  - this cycle is an idle operand-wait cycle
//   expire    - high during the idle cycle that exhausts the budget
// ---------------------------------------------------------------------------
module rx_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // The counter holds the number of idle cycles already seen, so the cycle
  // that finds it at LAST_COUNT is the one that uses up the budget.
  assign expire = count_en && (count == LAST_COUNT);

  // Idle-cycle counter; restarts on clear and after it has fired.
  always_ff @(posedge clk) begin
    if (!reset || clear || expire) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_alu_frame_if.sv
// ---------------------------------------------------------------------------
// uart_alu_frame_if
// Frame-based bridge between a UART RX/TX pair and a combinational ALU.
// A frame is one opcode byte followed by operand A and operand B, each
// NB_DATA/8 bytes sent least-significant byte first. The result is returned
// byte-serially, LSB first. A stalled frame is aborted after TIMEOUT_CYCLES
// idle cycles between operand bytes (0 disables the timeout).
//
// Optional feature macro: UART_ALU_STATUS_EN
//   defined   - a status byte (bit0 result==0, bit1 result MSB) follows the
//               result, and an aborted frame sends ERR_BYTE (0xE1)
//   undefined - result bytes only; aborts are silent apart from frame_err
//
// Ports:
//   clk, reset     - clock; synchronous active-low reset
//   rx_empty       - RX FIFO empty
//   rx_data        - RX FIFO head byte (show-ahead)
//   rx_rd          - pop strobe, asserted in the cycle rx_data is consumed
//   tx_done_tick   - UART TX finished the current byte
//   tx_start       - one-cycle TX start strobe
//   tx_data        - byte to transmit
//   alu_op         - registered opcode
//   alu_a, alu_b   - registered operands
//   alu_result     - combinational ALU result
//   busy           - high whenever the FSM is not idle
//   frame_err      - one-cycle pulse on a timeout abort
// ---------------------------------------------------------------------------
module uart_alu_frame_if
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA        = 16,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [7:0]         rx_data,
  output logic               rx_rd,
  input  logic               tx_done_tick,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [NB_OP-1:0]   alu_op,
  output logic [NB_DATA-1:0] alu_a,
  output logic [NB_DATA-1:0] alu_b,
  input  logic [NB_DATA-1:0] alu_result,
  output logic               busy,
  output logic               frame_err
);

  localparam int NB_BYTES = nb_bytes(NB_DATA);
  localparam int IDX_W    = idx_width(NB_DATA);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);
`ifdef UART_ALU_STATUS_EN
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NB_BYTES);
`endif

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_inc;
  logic [NB_DATA-1:0] res_reg;
  logic [7:0]         next_res_byte;
  logic               in_rx_state;
  logic               timeout_expire;
`ifdef UART_ALU_STATUS_EN
  logic               err_pending;
  logic [7:0]         status_byte;
`endif

  assign idx_inc     = idx + IDX_W'(1);
  assign in_rx_state = (state == S_READ_OP) || (state == S_READ_A) ||
                       (state == S_READ_B);

  // The pop is combinational so the byte is consumed in the same cycle it is
  // written; it is masked during reset so no byte is lost to a dead frame.
  assign rx_rd     = reset && !rx_empty && in_rx_state;
  assign busy      = (state != S_IDLE);
  assign frame_err = reset && timeout_expire;

  // Select the next result byte to transmit without indexing past the
  // result width.
  always_comb begin
    next_res_byte = '0;
    for (int i = 0; i < NB_BYTES; i++) begin
      if (idx_inc == IDX_W'(i)) begin
        next_res_byte = res_reg[8*i +: 8];
      end
    end
  end

`ifdef UART_ALU_STATUS_EN
  // Status byte summarising the captured result.
  always_comb begin
    status_byte                  = '0;
    status_byte[STATUS_ZERO_BIT] = (res_reg == '0);
    status_byte[STATUS_NEG_BIT]  = res_reg[NB_DATA-1];
  end
`endif

  // Timeout only watches the operand-wait states; with TIMEOUT_CYCLES of 0
  // the timer is left out and frames may stall forever.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_expire = 1'b0;
    end else begin : g_timeout
      logic in_operand_state;
      assign in_operand_state = (state == S_READ_A) || (state == S_READ_B);

      rx_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (rx_rd || !in_operand_state),
        .count_en(in_operand_state && rx_empty),
        .expire  (timeout_expire)
      );
    end
  endgenerate

  // Main frame FSM. tx_start and tx_data are loaded on the transition into
  // SEND, so tx_start is high exactly during the SEND cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      res_reg  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
`ifdef UART_ALU_STATUS_EN
      err_pending <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_empty) begin
            state <= S_READ_OP;
          end
        end

        S_READ_OP: begin
          if (!rx_empty) begin
            alu_op <= rx_data[NB_OP-1:0];
            idx    <= '0;
            state  <= S_READ_A;
          end
        end

        S_READ_A, S_READ_B: begin
          if (!rx_empty) begin
            for (int i = 0; i < NB_BYTES; i++) begin
              if (idx == IDX_W'(i)) begin
                if (state == S_READ_A) begin
                  alu_a[8*i +: 8] <= rx_data;
                end else begin
                  alu_b[8*i +: 8] <= rx_data;
                end
              end
            end
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= (state == S_READ_A) ? S_READ_B : S_COMPUTE;
            end else begin
              idx <= idx_inc;
            end
          end else if (timeout_expire) begin
            // Abort: drop the partial operands so a later frame starts clean.
            alu_a <= '0;
            alu_b <= '0;
            idx   <= '0;
`ifdef UART_ALU_STATUS_EN
            tx_data     <= ERR_BYTE;
            tx_start    <= 1'b1;
            err_pending <= 1'b1;
            state       <= S_SEND;
`else
            state <= S_IDLE;
`endif
          end
        end

        S_COMPUTE: begin
          res_reg  <= alu_result;
          idx      <= '0;
          tx_data  <= alu_result[7:0];
          tx_start <= 1'b1;
          state    <= S_SEND;
        end

        S_SEND: begin
          state <= S_WAIT_TX;
        end

        S_WAIT_TX: begin
          if (tx_done_tick) begin
`ifdef UART_ALU_STATUS_EN
            if (err_pending) begin
              err_pending <= 1'b0;
              state       <= S_IDLE;
            end else if (idx < LAST_IDX) begin
              idx      <= idx_inc;
              tx_data  <= next_res_byte;
              tx_start <= 1'b1;
              state    <= S_SEND;
            end else if (idx == LAST_IDX) begin
              idx      <= STATUS_IDX;
              tx_data  <= status_byte;
              tx_start <= 1'b1;
              state    <= S_SEND;
            end else begin
              idx   <= '0;
              state <= S_IDLE;
            end
`else
            if (idx < LAST_IDX) begin
              idx      <= idx_inc;
              tx_data  <= next_res_byte;
              tx_start <= 1'b1;
              state    <= S_SEND;
            end else begin
              idx   <= '0;
              state <= S_IDLE;
            end
`endif
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_frame_if
// Directed self-checking bench for uart_alu_frame_if with NB_DATA=16 and a
// 16-cycle inter-byte timeout. The RX FIFO is a small array model and the
// ALU model implements op 0x20 = ADD, op 0x22 = SUB. Expectations adapt to
// UART_ALU_STATUS_EN when it is defined for the build.
// ---------------------------------------------------------------------------
module tb_uart_alu_frame_if;

  localparam int NB_DATA = 16;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               rx_empty;
  logic [7:0]         rx_data;
  logic               rx_rd;
  logic               tx_done_tick;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_DATA-1:0] alu_result;
  logic               busy;
  logic               frame_err;

  int n_compared   = 0;
  int n_mismatched = 0;

  int cyc          = 0;
  int last_pop_cyc = -1;
  int bad_pops     = 0;
  int wr_ptr       = 0;
  int rd_ptr       = 0;
  logic [7:0] fifo_mem [0:63];

  always #5 clk = ~clk;

  // RX FIFO model: show-ahead head byte, popped on rx_rd at the clock edge.
  assign rx_empty = (rd_ptr == wr_ptr);
  assign rx_data  = rx_empty ? 8'h00 : fifo_mem[rd_ptr[5:0]];

  // Cycle counter and pop bookkeeping; a pop of an empty FIFO is recorded.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_rd === 1'b1) begin
      if (rd_ptr == wr_ptr) begin
        bad_pops <= bad_pops + 1;
      end else begin
        rd_ptr       <= rd_ptr + 1;
        last_pop_cyc <= cyc;
      end
    end
  end

  // Reference ALU.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  uart_alu_frame_if #(
    .NB_DATA       (NB_DATA),
    .NB_OP         (NB_OP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rx_rd       (rx_rd),
    .tx_done_tick(tx_done_tick),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .busy        (busy),
    .frame_err   (frame_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_frame(input logic [7:0] op, input logic [15:0] a,
                            input logic [15:0] b);
    push(op);
    push(a[7:0]);
    push(a[15:8]);
    push(b[7:0]);
    push(b[15:8]);
  endtask

  // Wait (bounded) for a tx_start, capture the byte, then answer with a
  // tx_done_tick two cycles later. Returns the cycles of start and done.
  task automatic recv_tx(output logic [7:0] b, output int start_cyc,
                         output int done_cyc, output bit got);
    got       = 1'b0;
    b         = '0;
    start_cyc = -1;
    done_cyc  = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      if (tx_start === 1'b1) begin
        got       = 1'b1;
        b         = tx_data;
        start_cyc = cyc;
      end else begin
        tick();
      end
    end
    if (got) begin
      tick();
      tick();
      tx_done_tick = 1'b1;
      done_cyc     = cyc;
      tick();
      tx_done_tick = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    tx_done_tick = 1'b0;
    repeat (3) tick();
    n_compared++;
    if ({rx_rd, tx_start, busy, frame_err} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000",
               {rx_rd, tx_start, busy, frame_err});
    end
    n_compared++;
    if ({alu_op, alu_a, alu_b, tx_data} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got op=%h a=%h b=%h tx=%h expected all 0",
               alu_op, alu_a, alu_b, tx_data);
    end
    reset = 1'b1;
    repeat (2) tick();
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_add_frame();
    logic [7:0] b;
    int sc, dc, dc0;
    bit got;
    push_frame(8'h20, 16'h1234, 16'h0001);
    recv_tx(b, sc, dc, got);
    n_compared++;
    if (!got || b !== 8'h35) begin
      n_mismatched++;
      $display("[TB] FAIL add_byte0: got %h (seen=%0d) expected 35", b, got);
    end
    n_compared++;
    if (sc !== last_pop_cyc + 2) begin
      n_mismatched++;
      $display("[TB] FAIL add_start_latency: got cycle %0d expected %0d",
               sc, last_pop_cyc + 2);
    end
    n_compared++;
    if ({alu_op, alu_a, alu_b} !== {6'h20, 16'h1234, 16'h0001}) begin
      n_mismatched++;
      $display("[TB] FAIL add_operands: got op=%h a=%h b=%h expected 20 1234 0001",
               alu_op, alu_a, alu_b);
    end
    dc0 = dc;
    recv_tx(b, sc, dc, got);
    n_compared++;
    if (!got || b !== 8'h12) begin
      n_mismatched++;
      $display("[TB] FAIL add_byte1: got %h (seen=%0d) expected 12", b, got);
    end
    n_compared++;
    if (sc !== dc0 + 1) begin
      n_mismatched++;
      $display("[TB] FAIL add_done_to_start: got cycle %0d expected %0d",
               sc, dc0 + 1);
    end
`ifdef UART_ALU_STATUS_EN
    recv_tx(b, sc, dc, got);
    n_compared++;
    if (!got || b !== 8'h00) begin
      n_mismatched++;
      $display("[TB] FAIL add_status: got %h (seen=%0d) expected 00", b, got);
    end
`endif
    repeat (3) tick();
    n_compared++;
    if ({busy, tx_start} !== 2'b00) begin
      n_mismatched++;
      $display("[TB] FAIL add_idle: got busy/start %b expected 00",
               {busy, tx_start});
    end
  endtask

  task automatic test_sub_status();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sc, dc;
    bit got;
    exp_q = '{8'h00, 8'h00};
`ifdef UART_ALU_STATUS_EN
    exp_q.push_back(8'h01);
`endif
    push_frame(8'h22, 16'h0005, 16'h0005);
    foreach (exp_q[k]) begin
      recv_tx(b, sc, dc, got);
      n_compared++;
      if (!got || b !== exp_q[k]) begin
        n_mismatched++;
        $display("[TB] FAIL sub_byte%0d: got %h (seen=%0d) expected %h",
                 k, b, got, exp_q[k]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sc, dc;
    int err_cyc;
    bit got;
    bit err_seen;
    push(8'h20);
    push(8'h34);
    err_seen = 1'b0;
    err_cyc  = -1;
    for (int i = 0; i < 60 && !err_seen; i++) begin
      if (frame_err === 1'b1) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end else begin
        tick();
      end
    end
    n_compared++;
    if (!err_seen || err_cyc !== last_pop_cyc + TIMEOUT) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_cycle: got cycle %0d (seen=%0d) expected %0d",
               err_cyc, err_seen, last_pop_cyc + TIMEOUT);
    end
    n_compared++;
    if (alu_a !== 16'h0034) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_partial_a: got %h expected 0034", alu_a);
    end
    tick();
    n_compared++;
    if (frame_err !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_pulse_width: got %b expected 0", frame_err);
    end
    n_compared++;
    if ({alu_a, alu_b} !== 32'h0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_operands_cleared: got a=%h b=%h expected 0",
               alu_a, alu_b);
    end
`ifdef UART_ALU_STATUS_EN
    n_compared++;
    if (busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_busy_err_byte: got %b expected 1", busy);
    end
    recv_tx(b, sc, dc, got);
    n_compared++;
    if (!got || b !== 8'hE1) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_err_byte: got %h (seen=%0d) expected e1", b, got);
    end
`endif
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL timeout_busy_fall: got %b expected 0", busy);
    end
    exp_q = '{8'h03, 8'h00};
`ifdef UART_ALU_STATUS_EN
    exp_q.push_back(8'h00);
`endif
    push_frame(8'h20, 16'h0001, 16'h0002);
    foreach (exp_q[k]) begin
      recv_tx(b, sc, dc, got);
      n_compared++;
      if (!got || b !== exp_q[k]) begin
        n_mismatched++;
        $display("[TB] FAIL after_timeout_byte%0d: got %h (seen=%0d) expected %h",
                 k, b, got, exp_q[k]);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sc, dc;
    int start_rd;
    bit got;
    exp_q = '{8'h03, 8'h00};
`ifdef UART_ALU_STATUS_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h00);
`ifdef UART_ALU_STATUS_EN
    exp_q.push_back(8'h00);
`endif
    start_rd = rd_ptr;
    push_frame(8'h20, 16'h0001, 16'h0002);
    push_frame(8'h22, 16'h0010, 16'h0003);
    foreach (exp_q[k]) begin
      recv_tx(b, sc, dc, got);
      n_compared++;
      if (!got || b !== exp_q[k]) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_byte%0d: got %h (seen=%0d) expected %h",
                 k, b, got, exp_q[k]);
      end
    end
    repeat (3) tick();
    n_compared++;
    if (rd_ptr - start_rd !== 10 || bad_pops !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_pops: got %0d pops, %0d empty pops expected 10, 0",
               rd_ptr - start_rd, bad_pops);
    end
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_idle: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_tx();
    bit got;
    bit stray;
    push_frame(8'h20, 16'h0001, 16'h0001);
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (tx_start === 1'b1) got = 1'b1;
      else tick();
    end
    n_compared++;
    if (!got || tx_data !== 8'h02) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_first_byte: got %h (seen=%0d) expected 02",
               tx_data, got);
    end
    tick();
    reset = 1'b0;
    tick();
    n_compared++;
    if ({rx_rd, tx_start, busy, frame_err} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_ctrl: got %b expected 0000",
               {rx_rd, tx_start, busy, frame_err});
    end
    n_compared++;
    if ({alu_op, alu_a, alu_b, tx_data} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_data: got op=%h a=%h b=%h tx=%h expected all 0",
               alu_op, alu_a, alu_b, tx_data);
    end
    reset        = 1'b1;
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || tx_start !== 1'b0) stray = 1'b1;
      tick();
    end
    n_compared++;
    if (stray !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL rst_mid_spurious_done: got activity %b expected 0", stray);
    end
  endtask

  task automatic test_spurious_done();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int sc, dc;
    bit got;
    push(8'h20);
    push(8'h10);
    repeat (4) tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    tick();
    n_compared++;
    if ({busy, tx_start, alu_a} !== {1'b1, 1'b0, 16'h0010}) begin
      n_mismatched++;
      $display("[TB] FAIL spurious_in_read_a: got busy=%b start=%b a=%h expected 1 0 0010",
               busy, tx_start, alu_a);
    end
    push(8'h00);
    push(8'h05);
    push(8'h00);
    exp_q = '{8'h15, 8'h00};
`ifdef UART_ALU_STATUS_EN
    exp_q.push_back(8'h00);
`endif
    foreach (exp_q[k]) begin
      recv_tx(b, sc, dc, got);
      n_compared++;
      if (!got || b !== exp_q[k]) begin
        n_mismatched++;
        $display("[TB] FAIL spurious_byte%0d: got %h (seen=%0d) expected %h",
                 k, b, got, exp_q[k]);
      end
    end
    repeat (2) tick();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_add_frame();
    test_sub_status();
    test_timeout();
    test_back_to_back();
    test_reset_mid_tx();
    test_spurious_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

  // Hard stop in case a stimulus loop never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
